// File: rtl/line_memory_responder.sv
// line_memory_responder: fixed-latency single-outstanding 256-bit line memory answering dcache requests
module line_memory_responder #(
  parameter int DEPTH   = 512,
  parameter int LATENCY = 10
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         enable_i,
  input  logic         write_i,
  input  logic [31:0]  addr_i,
  input  logic [255:0] data_i,
  output logic         ack_o,
  output logic [255:0] data_o
);
  localparam int IW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;
  state_t          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            wr_q;
  logic [IW-1:0]   idx_q;
  logic [255:0]    wdat_q;
  logic            ack_q;
  logic [255:0]    rdat_q;
  logic [255:0]    mem [DEPTH];
  logic            accept, fire, f_wr;
  logic [IW-1:0]   f_idx;
  logic [255:0]    f_dat;
  logic            unused_addr;
  assign unused_addr = ^{addr_i[4:0], addr_i[31:5+IW]};
  assign ack_o  = ack_q;
  assign data_o = rdat_q;
  // Next state: accept in IDLE, count down in BUSY, fire the access on the edge that enters ACK
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    fire    = 1'b0;
    case (state_q)
      IDLE: if (enable_i) begin
        accept  = 1'b1;
        cnt_d   = 8'(LATENCY - 1);
        fire    = LATENCY == 1;
        state_d = LATENCY == 1 ? ACK : BUSY;
      end
      BUSY: begin
        fire    = cnt_q == 8'd0;
        cnt_d   = fire ? 8'd0 : cnt_q - 8'd1;
        state_d = fire ? ACK : BUSY;
      end
      default: state_d = IDLE;
    endcase
    f_wr  = accept ? write_i : wr_q;
    f_idx = accept ? addr_i[5 +: IW] : idx_q;
    f_dat = accept ? data_i : wdat_q;
  end
  // State, counter, latched request and read data; reset drops any in-flight request
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      ack_q   <= 1'b0;
      rdat_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= fire;
      if (accept) begin
        wr_q   <= write_i;
        idx_q  <= addr_i[5 +: IW];
        wdat_q <= data_i;
      end
      if (fire && !f_wr) rdat_q <= mem[f_idx];
    end
  end
  // Line storage, never cleared; a write commits on its ack edge unless reset is asserted
  always_ff @(posedge clk_i) begin
    if (rst_i && fire && f_wr) mem[f_idx] <= f_dat;
  end
endmodule

// File: tb/tb_line_memory_responder.sv
// tb_line_memory_responder: directed and randomized checks against a line-array reference model
module tb_line_memory_responder;
  localparam int DEPTH = 512;
  localparam int LAT   = 10;
  logic         clk = 0;
  logic         rst = 0;
  logic         en = 0;
  logic         we = 0;
  logic [31:0]  addr = 0;
  logic [255:0] din = 0;
  logic         ack_o;
  logic [255:0] data_o;
  int           checks = 0;
  int           fails = 0;
  int           acks = 0;
  logic [255:0] mm [DEPTH];
  bit           vld [DEPTH];
  logic [255:0] last = 0;

  line_memory_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(en), .write_i(we), .addr_i(addr),
    .data_i(din), .ack_o(ack_o), .data_o(data_o)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (ack_o === 1'b1) acks++;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int line_of(input logic [31:0] a);
    return int'((a / 32) % DEPTH);
  endfunction

  function automatic logic [255:0] rnd256();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic scramble();
    en = 0;
    we = 1'($urandom);
    addr = $urandom;
    din = rnd256();
  endtask

  task automatic transact(input logic wr, input logic [31:0] a, input logic [255:0] d, input int chg);
    int n;
    int idx;
    logic [255:0] exp;
    idx = line_of(a);
    exp = wr ? last : mm[idx];
    @(negedge clk);
    en = 1; we = wr; addr = a; din = d;
    @(posedge clk); #1;
    n = 0;
    if (chg == 0) scramble();
    while (ack_o !== 1'b1 && n < LAT + 4) begin
      @(posedge clk); #1;
      n++;
      if (n == chg) scramble();
    end
    en = 0;
    check(wr ? "wr_latency" : "rd_latency", 256'(n), 256'(LAT));
    check(wr ? "wr_data_o_hold" : "rd_data", data_o, exp);
    if (wr) begin
      mm[idx] = d;
      vld[idx] = 1;
    end else last = exp;
    @(posedge clk); #1;
    check("ack_pulse", 256'(ack_o), 256'(0));
  endtask

  initial begin
    int n;
    int a0;
    logic [255:0] p5;
    logic [255:0] d1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ack", 256'(ack_o), 256'(0));
    check("rst_data", data_o, 256'(0));
    rst = 1;
    // 1: read timing after preload of line 3
    transact(1, 32'h60, {32{8'hA5}}, LAT + 1);
    transact(0, 32'h60, 0, LAT + 1);
    // 2: write then read, exactly two acks
    a0 = acks;
    transact(1, 32'h80, 256'h1234, LAT + 1);
    transact(0, 32'h80, 0, LAT + 1);
    check("two_acks", 256'(acks - a0), 256'(2));
    check("wr_rd_1234", data_o, 256'h1234);
    // 4: wrap-around aliasing
    transact(1, 32'h4000, 256'hBEEF, LAT + 1);
    transact(0, 32'h0000, 0, LAT + 1);
    check("wrap_beef", data_o, 256'hBEEF);
    // 6: input change and enable drop during BUSY
    transact(0, 32'h60, 0, 3);
    check("busy_change", data_o, {32{8'hA5}});
    // 3: back-to-back with enable held across the ack
    transact(1, 32'h40, rnd256(), LAT + 1);
    d1 = rnd256();
    @(negedge clk);
    en = 1; we = 1; addr = 32'h20; din = d1;
    @(posedge clk); #1;
    n = 0;
    while (ack_o !== 1'b1 && n < LAT + 4) begin @(posedge clk); #1; n++; end
    check("b2b_first_lat", 256'(n), 256'(LAT));
    mm[1] = d1; vld[1] = 1;
    we = 0; addr = 32'h40;
    @(posedge clk); #1;
    n = 1;
    check("b2b_ack_drop", 256'(ack_o), 256'(0));
    while (ack_o !== 1'b1 && n < LAT + 6) begin @(posedge clk); #1; n++; end
    en = 0;
    check("b2b_second_lat", 256'(n), 256'(LAT + 2));
    check("b2b_data", data_o, mm[2]);
    last = mm[2];
    @(posedge clk); #1;
    check("b2b_pulse", 256'(ack_o), 256'(0));
    transact(0, 32'h20, 0, LAT + 1);
    // 5: reset mid-write drops it
    p5 = rnd256();
    transact(1, 32'hA0, p5, LAT + 1);
    @(negedge clk);
    en = 1; we = 1; addr = 32'hA0; din = 256'hDEAD;
    @(posedge clk); #1;
    en = 0;
    repeat (4) @(posedge clk);
    #1 rst = 0;
    @(posedge clk); #1;
    rst = 1;
    check("midrst_ack", 256'(ack_o), 256'(0));
    check("midrst_data", data_o, 256'(0));
    last = 0;
    a0 = acks;
    repeat (12) @(posedge clk);
    #1;
    check("midrst_no_ack", 256'(acks - a0), 256'(0));
    transact(0, 32'hA0, 0, LAT + 1);
    check("midrst_prior", data_o, p5);
    // randomized traffic over a small line pool with random alias bits
    for (int i = 0; i < 30; i++) begin
      int idx;
      logic wr;
      logic [31:0] a;
      idx = $urandom_range(0, 15);
      a = ($urandom & 32'hFFFF_C01F) | (32'(idx) << 5);
      wr = !vld[idx] || 1'($urandom);
      transact(wr, a, rnd256(), $urandom_range(0, LAT - 1));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
